// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the parameterised cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  localparam int POLICY_LRU = 0;
  localparam int POLICY_RR  = 1;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int set_bits);
    return set_bits;
  endfunction

  function automatic int tag_bits(input int set_bits, input int line_words);
    return 32 - 2 - $clog2(line_words) - set_bits;
  endfunction

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/pcache_set.sv
// One cache set: line storage, tag compare, victim choice and a single
// way/word access port shared by hit, refill, writeback and respond traffic.
module pcache_set
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 26,
  parameter int WAY_W      = 1,
  parameter int POLICY     = POLICY_LRU
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TAG_W-1:0]              lk_tag,
  output logic                          hit,
  output logic [WAY_W-1:0]              hit_way,
  output logic [WAY_W-1:0]              vict_way,
  output logic                          vict_valid,
  output logic                          vict_dirty,
  output logic [TAG_W-1:0]              vict_tag,
  input  logic [WAY_W-1:0]              acc_way,
  input  logic [$clog2(LINE_WORDS)-1:0] acc_idx,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic                          set_dirty,
  input  logic                          stamp,
  input  logic [31:0]                   now,
  input  logic                          fill,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic                          fill_adv
);

  logic [WAYS-1:0]                        valid, dirty;
  logic [WAYS-1:0][TAG_W-1:0]             tags;
  logic [WAYS-1:0][31:0]                  ticks;
  logic [WAYS-1:0][LINE_WORDS-1:0][31:0]  data;
  logic [WAY_W-1:0]                       rr;

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && tags[w] == lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    logic        found;
    logic [31:0] best;
    found    = 1'b0;
    best     = ticks[0];
    vict_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        found    = 1'b1;
        vict_way = WAY_W'(w);
      end
    end
    if (!found) begin
      if (POLICY == POLICY_RR) begin
        vict_way = rr;
      end else begin
        for (int w = 1; w < WAYS; w++) begin
          if (ticks[w] < best) begin
            best     = ticks[w];
            vict_way = WAY_W'(w);
          end
        end
      end
    end
  end

  assign vict_valid = valid[vict_way];
  assign vict_dirty = dirty[vict_way];
  assign vict_tag   = tags[vict_way];
  assign rd_data    = data[acc_way][acc_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
      ticks <= '0;
      rr    <= '0;
    end else begin
      if (set_dirty) dirty[acc_way] <= 1'b1;
      if (stamp)     ticks[acc_way] <= now;
      if (fill) begin
        valid[acc_way] <= 1'b1;
        dirty[acc_way] <= 1'b0;
        if (POLICY == POLICY_RR && fill_adv)
          rr <= (rr == WAY_W'(WAYS - 1)) ? '0 : rr + 1'b1;
      end
    end
  end

  // Payload needs no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) data[acc_way][acc_idx] <= wr_data;
    if (fill)  tags[acc_way]          <= fill_tag;
  end

endmodule

// File: rtl/param_cache.sv
// Blocking set-associative write-back cache with a single-beat memory port;
// hits answer in one cycle, misses write back a dirty victim then refill.
module param_cache
  import cache_pkg::*;
#(
  parameter int SET_BITS   = 2,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int POLICY     = POLICY_LRU
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        busy
);

  localparam int OFF_W  = off_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(SET_BITS);
  localparam int TAG_W  = tag_bits(SET_BITS, LINE_WORDS);
  localparam int WAY_W  = way_bits(WAYS);
  localparam int SETS   = 1 << SET_BITS;
  localparam int IDX_LO = 2 + OFF_W;
  localparam int TAG_LO = IDX_LO + IDX_W;

  state_t            state;
  logic [31:0]       now, data_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q, beat;
  logic              write_q, vvalid_q, mem_vld_q, resp_vld_q;
  logic [WAY_W-1:0]  vway_q;

  logic [TAG_W-1:0]  req_tag, lk_tag;
  logic [IDX_W-1:0]  req_idx, cur_idx;
  logic [OFF_W-1:0]  req_off, acc_idx;
  logic [WAY_W-1:0]  acc_way;
  logic              accept, beat_done, last, unused_bits;
  logic              wr_en, set_dirty, stamp, fill;
  logic [31:0]       wr_data;

  logic [SETS-1:0]             s_hit, s_vvalid, s_vdirty;
  logic [SETS-1:0][WAY_W-1:0]  s_hit_way, s_vway;
  logic [SETS-1:0][TAG_W-1:0]  s_vtag;
  logic [SETS-1:0][31:0]       s_rd;

  logic              sel_hit, sel_vvalid, sel_vdirty;
  logic [WAY_W-1:0]  sel_hit_way, sel_vway;
  logic [TAG_W-1:0]  sel_vtag;
  logic [31:0]       sel_rd;

  assign req_off     = req_addr[IDX_LO-1:2];
  assign req_idx     = req_addr[TAG_LO-1:IDX_LO];
  assign req_tag     = req_addr[31:TAG_LO];
  assign unused_bits = ^req_addr[1:0];

  assign req_ready  = en && state == IDLE;
  assign accept     = req_valid && req_ready;
  assign busy       = state != IDLE;
  assign mem_valid  = mem_vld_q && en;
  assign resp_valid = resp_vld_q && en;
  assign beat_done  = mem_valid && mem_ready;
  assign last       = beat == OFF_W'(LINE_WORDS - 1);

  assign cur_idx     = (state == IDLE) ? req_idx : idx_q;
  assign lk_tag      = (state == IDLE) ? req_tag : tag_q;
  assign sel_hit     = s_hit[cur_idx];
  assign sel_hit_way = s_hit_way[cur_idx];
  assign sel_vway    = s_vway[cur_idx];
  assign sel_vvalid  = s_vvalid[cur_idx];
  assign sel_vdirty  = s_vdirty[cur_idx];
  assign sel_vtag    = s_vtag[cur_idx];
  assign sel_rd      = s_rd[cur_idx];

  // In IDLE a miss reads victim word 0 so the first writeback beat is ready
  // on the cycle the transfer starts; WRITEBACK prefetches the next word.
  always_comb begin
    acc_way = vway_q;
    acc_idx = off_q;
    case (state)
      IDLE: begin
        acc_way = sel_hit ? sel_hit_way : sel_vway;
        acc_idx = sel_hit ? req_off : '0;
      end
      WRITEBACK: acc_idx = beat + 1'b1;
      REFILL:    acc_idx = beat;
      default: ;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    set_dirty = 1'b0;
    stamp     = 1'b0;
    fill      = 1'b0;
    wr_data   = data_q;
    case (state)
      IDLE: begin
        wr_en     = accept && sel_hit && req_write;
        set_dirty = accept && sel_hit && req_write;
        stamp     = accept && sel_hit;
        wr_data   = req_data;
      end
      REFILL: begin
        wr_en   = beat_done;
        fill    = beat_done && last;
        wr_data = mem_rdata;
      end
      RESPOND: begin
        wr_en     = en && write_q;
        set_dirty = en && write_q;
        stamp     = en;
      end
      default: ;
    endcase
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic sel;
    assign sel = cur_idx == IDX_W'(s);
    pcache_set #(
      .WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .WAY_W(WAY_W), .POLICY(POLICY)
    ) u_set (
      .clk       (clk),
      .reset     (reset),
      .lk_tag    (lk_tag),
      .hit       (s_hit[s]),
      .hit_way   (s_hit_way[s]),
      .vict_way  (s_vway[s]),
      .vict_valid(s_vvalid[s]),
      .vict_dirty(s_vdirty[s]),
      .vict_tag  (s_vtag[s]),
      .acc_way   (acc_way),
      .acc_idx   (acc_idx),
      .rd_data   (s_rd[s]),
      .wr_en     (wr_en && sel),
      .wr_data   (wr_data),
      .set_dirty (set_dirty && sel),
      .stamp     (stamp && sel),
      .now       (now),
      .fill      (fill && sel),
      .fill_tag  (tag_q),
      .fill_adv  (vvalid_q)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      now        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      write_q    <= 1'b0;
      vway_q     <= '0;
      vvalid_q   <= 1'b0;
      beat       <= '0;
      mem_vld_q  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_vld_q <= 1'b0;
      resp_data  <= '0;
    end else if (en) begin
      now        <= now + 32'd1;
      resp_vld_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (sel_hit) begin
            hit_count  <= hit_count + 32'd1;
            resp_vld_q <= 1'b1;
            resp_data  <= req_write ? req_data : sel_rd;
          end else begin
            miss_count <= miss_count + 32'd1;
            tag_q      <= req_tag;
            idx_q      <= req_idx;
            off_q      <= req_off;
            data_q     <= req_data;
            write_q    <= req_write;
            vway_q     <= sel_vway;
            vvalid_q   <= sel_vvalid;
            beat       <= '0;
            mem_vld_q  <= 1'b1;
            if (sel_vvalid && sel_vdirty) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {sel_vtag, req_idx, {(OFF_W + 2){1'b0}}};
              mem_wdata <= sel_rd;
            end else begin
              state     <= REFILL;
              mem_write <= 1'b0;
              mem_addr  <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
              mem_wdata <= '0;
            end
          end
        end
        WRITEBACK: if (beat_done) begin
          if (last) begin
            state     <= REFILL;
            beat      <= '0;
            mem_write <= 1'b0;
            mem_addr  <= {tag_q, idx_q, {(OFF_W + 2){1'b0}}};
            mem_wdata <= '0;
          end else begin
            beat      <= beat + 1'b1;
            mem_addr  <= mem_addr + 32'd4;
            mem_wdata <= sel_rd;
          end
        end
        REFILL: if (beat_done) begin
          if (last) begin
            state     <= RESPOND;
            mem_vld_q <= 1'b0;
          end else begin
            beat     <= beat + 1'b1;
            mem_addr <= mem_addr + 32'd4;
          end
        end
        RESPOND: begin
          state      <= IDLE;
          resp_vld_q <= 1'b1;
          resp_data  <= write_q ? data_q : sel_rd;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL have parameter SET_BITS, default 2, log2 of set count.
REQ-002 SHALL have parameter WAYS, default 2, lines per set (1..8).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL have parameter POLICY, default 0, replacement mode: 0 = LRU, 1 = per-set round-robin.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have ports: en  in  1  global enable; req_valid  in  1; req_ready  out  1; req_write  in  1; req_addr  in  32; req_data  in  32.
REQ-007 SHALL have ports: resp_valid  out  1  one-cycle response pulse; resp_data  out  32  read data or echoed write data.
REQ-008 SHALL have ports: mem_valid  out  1; mem_write  out  1; mem_addr  out  32; mem_wdata  out  32; mem_ready  in  1; mem_rdata  in  32, valid in the mem_valid&&mem_ready cycle.
REQ-009 SHALL have ports: hit_count  out  32; miss_count  out  32; busy  out  1 (state != IDLE).

Function
REQ-010 SHALL split req_addr as: [1:0] ignored, word offset log2(LINE_WORDS) bits, index SET_BITS bits, tag the remaining upper bits.
REQ-011 SHALL use states IDLE, WRITEBACK, REFILL, RESPOND; req_ready = en && state==IDLE.
REQ-012 SHALL accept a request when req_valid && req_ready; tag compare is combinational in that cycle.
REQ-013 Hit: SHALL assert resp_valid exactly one cycle after acceptance, stay in IDLE, increment hit_count.
REQ-014 Write hit SHALL update the word, set dirty; resp_data = req_data.
REQ-015 Miss: SHALL latch addr/data/write, increment miss_count, select victim, go to WRITEBACK if victim valid&&dirty, else REFILL.
REQ-016 WRITEBACK SHALL issue LINE_WORDS write beats at old-tag line base + 4*k, k ascending, then go to REFILL.
REQ-017 REFILL SHALL issue LINE_WORDS read beats at new line base + 4*k, storing mem_rdata; then set valid, clear dirty, go to RESPOND.
REQ-018 A beat completes only when mem_valid && mem_ready; mem_addr/mem_wdata/mem_write SHALL stay stable while mem_ready is low.
REQ-019 RESPOND SHALL perform the latched access on the filled line (write-allocate: write sets dirty), pulse resp_valid, return to IDLE.
REQ-020 Victim: first invalid way (lowest index); else POLICY 0 smallest tick (ties lowest index), POLICY 1 the set's round-robin pointer.
REQ-021 LRU: free-running 32-bit now counter increments each en cycle, wraps; a hit or RESPOND access stamps line tick = now.
REQ-022 Round-robin pointer SHALL advance modulo WAYS on each refill of a valid-victim set only.
REQ-023 en low SHALL freeze all state, counters, now; mem_valid and resp_valid SHALL be 0 while en is low.
REQ-024 hit_count and miss_count SHALL wrap modulo 2^32.

Reset
REQ-025 Reset SHALL clear all valid, dirty, tick, round-robin pointers, now, hit_count, miss_count; state = IDLE.
REQ-026 During and one cycle after reset: resp_valid, mem_valid, mem_write, busy = 0; mem_addr, mem_wdata, resp_data = 0.
REQ-027 Reset mid-WRITEBACK/REFILL SHALL abort the transfer; in-flight request is dropped with no response.

Structure
REQ-028 Package cache_pkg SHALL hold the state enum, POLICY constants, and tag/index/offset width functions.
REQ-029 Sub-module pcache_set SHALL hold one set's lines, tag compare, hit way, and victim selection; instantiated 2^SET_BITS times.

Verification (SET_BITS=2, WAYS=2, LINE_WORDS=4; set 0 = 0x00, 0x40, 0x80)
REQ-030 Cold read 0x10 -> refill beats 0x10,0x14,0x18,0x1C, resp_data = mem word at 0x10, miss_count=1; then read 0x14 -> resp next cycle, hit_count=1, no mem_valid.
REQ-031 POLICY 0: write 0x00=0xDEADBEEF, read 0x40, read 0x40, read 0x80 -> writeback 0x00..0x0C with word0=0xDEADBEEF, then refill 0x80..0x8C; 0x40 still hits.
REQ-032 POLICY 1: same sequence -> victims way0, way1, then way0 (0x00 line) evicted regardless of access order.
REQ-033 mem_ready low 3 cycles mid-refill -> mem_addr stable, beat count unchanged, total refill 4 beats.
REQ-034 en low 2 cycles in REFILL -> no state/now change; reset in WRITEBACK -> next cycle IDLE, mem_valid=0, a read of 0x00 misses.
